// File: rtl/adc_sample_shuffler_pkg.sv
// Shared definitions for the ADC sample shuffler: mode encodings, FSM states,
// sample geometry and the de-interleave index map.
package adc_sample_shuffler_pkg;

  localparam int SAMPLE_W      = 8;
  localparam int WORD_SAMPLES  = 8;
  localparam int BEAT_SAMPLES  = 16;
  localparam int WORD_W        = SAMPLE_W * WORD_SAMPLES;
  localparam int BEAT_W        = SAMPLE_W * BEAT_SAMPLES;

  localparam logic [1:0] MODE_1CH = 2'b00;
  localparam logic [1:0] MODE_2CH = 2'b01;
  localparam logic [1:0] MODE_4CH = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  // Both 1x encodings select four channels.
  function automatic logic [1:0] normalize_mode(input logic [1:0] mode);
    return mode[1] ? MODE_4CH : mode;
  endfunction

  // Input sample feeding output byte k when the beat carries n_ch channels.
  function automatic int deint_src(input int n_ch, input int k);
    int m;
    m = BEAT_SAMPLES / n_ch;
    return (k % m) * n_ch + (k / m);
  endfunction

endpackage

// File: rtl/adc_sample_shuffler_sample_deinterleave.sv
// Combinational 16-sample shuffle that groups each channel's samples into a
// contiguous run of bytes; the parent registers the result.
module sample_deinterleave
  import adc_sample_shuffler_pkg::*;
(
  input  logic [BEAT_W-1:0] pair,
  input  logic [1:0]        mode,
  output logic [BEAT_W-1:0] beat
);

  for (genvar gi = 0; gi < BEAT_SAMPLES; gi++) begin : g_byte
    localparam int SRC_1CH = deint_src(1, gi);
    localparam int SRC_2CH = deint_src(2, gi);
    localparam int SRC_4CH = deint_src(4, gi);

    assign beat[gi*SAMPLE_W +: SAMPLE_W] =
        mode[1] ? pair[SRC_4CH*SAMPLE_W +: SAMPLE_W] :
        mode[0] ? pair[SRC_2CH*SAMPLE_W +: SAMPLE_W] :
                  pair[SRC_1CH*SAMPLE_W +: SAMPLE_W];
  end

endmodule

// File: rtl/adc_sample_shuffler.sv
// Pairs 64-bit ADC words into 128-bit channel-de-interleaved beats for the
// FIFO write port, with settle gating, mode capture and overflow accounting.
module adc_sample_shuffler
  import adc_sample_shuffler_pkg::*;
#(
  parameter int SETTLE_WORDS = 16,
  parameter int CNT_W        = 16
) (
  input  logic              adc_divclk,
  input  logic              rst,
  input  logic [WORD_W-1:0] adc_data,
  input  logic              serdes_ready,
  input  logic              ddr_ready,
  input  logic [1:0]        ch_mode,
  input  logic              fifo_full,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_valid,
  output logic [1:0]        mode_active,
  output logic [CNT_W-1:0]  overflow_count,
  output logic              drop_sticky
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_WORDS - 1);

  logic              ddr_meta_reg, ddr_sync_reg;
  logic [1:0]        ch_mode_meta_reg, ch_mode_sync_reg;
  state_t            state_reg, state_next;
  logic [7:0]        settle_cnt_reg, settle_cnt_next;
  logic              phase_reg, phase_next;
  logic              accept;
  logic              beat_done;
  logic              mode_load;
  logic              q;
  logic [WORD_W-1:0] low_word_reg;
  logic [1:0]        mode_active_reg;
  logic [BEAT_W-1:0] pair_reg;
  logic [1:0]        pair_mode_reg;
  logic              pair_pend_reg;
  logic [BEAT_W-1:0] shuffled;
  logic [BEAT_W-1:0] out_data_reg;
  logic              out_valid_reg;
  logic [CNT_W-1:0]  overflow_count_reg;
  logic              drop_sticky_reg;

  always_ff @(posedge adc_divclk or posedge rst) begin
    if (rst) begin
      ddr_meta_reg     <= 1'b0;
      ddr_sync_reg     <= 1'b0;
      ch_mode_meta_reg <= MODE_1CH;
      ch_mode_sync_reg <= MODE_1CH;
    end else begin
      ddr_meta_reg     <= ddr_ready;
      ddr_sync_reg     <= ddr_meta_reg;
      ch_mode_meta_reg <= ch_mode;
      ch_mode_sync_reg <= ch_mode_meta_reg;
    end
  end

  assign q = serdes_ready & ddr_sync_reg;

  always_ff @(posedge adc_divclk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      settle_cnt_reg <= 8'd0;
      phase_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      settle_cnt_reg <= settle_cnt_next;
      phase_reg      <= phase_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    settle_cnt_next = settle_cnt_reg;
    phase_next      = phase_reg;
    accept          = 1'b0;
    if (!q) begin
      state_next      = IDLE;
      settle_cnt_next = 8'd0;
      phase_next      = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next      = SETTLE;
          settle_cnt_next = 8'd0;
        end
        SETTLE: begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            state_next      = RUN;
            settle_cnt_next = 8'd0;
          end else begin
            settle_cnt_next = settle_cnt_reg + 8'd1;
          end
        end
        RUN: begin
          accept     = 1'b1;
          phase_next = ~phase_reg;
        end
        default: begin
          state_next      = IDLE;
          settle_cnt_next = 8'd0;
          phase_next      = 1'b0;
        end
      endcase
    end
  end

  assign beat_done = accept & phase_reg;
  // Mode only moves between beats, so a pair is always shuffled consistently.
  assign mode_load = (state_reg != RUN) | ~phase_reg;

  always_ff @(posedge adc_divclk or posedge rst) begin
    if (rst) begin
      low_word_reg       <= '0;
      mode_active_reg    <= MODE_1CH;
      pair_reg           <= '0;
      pair_mode_reg      <= MODE_1CH;
      pair_pend_reg      <= 1'b0;
      out_data_reg       <= '0;
      out_valid_reg      <= 1'b0;
      overflow_count_reg <= '0;
      drop_sticky_reg    <= 1'b0;
    end else begin
      if (mode_load) begin
        mode_active_reg <= normalize_mode(ch_mode_sync_reg);
      end
      if (accept && !phase_reg) begin
        low_word_reg <= adc_data;
      end
      pair_pend_reg <= beat_done & ~fifo_full;
      if (beat_done && !fifo_full) begin
        pair_reg      <= {adc_data, low_word_reg};
        pair_mode_reg <= mode_active_reg;
      end
      if (beat_done && fifo_full) begin
        drop_sticky_reg <= 1'b1;
        if (overflow_count_reg != '1) begin
          overflow_count_reg <= overflow_count_reg + CNT_W'(1);
        end
      end
      out_valid_reg <= pair_pend_reg;
      if (pair_pend_reg) begin
        out_data_reg <= shuffled;
      end
    end
  end

  sample_deinterleave u_deinterleave (
    .pair (pair_reg),
    .mode (pair_mode_reg),
    .beat (shuffled)
  );

  assign out_data       = out_data_reg;
  assign out_valid      = out_valid_reg;
  assign mode_active    = mode_active_reg;
  assign overflow_count = overflow_count_reg;
  assign drop_sticky    = drop_sticky_reg;

endmodule

// File: tb/tb_adc_sample_shuffler.sv
// Directed testbench for adc_sample_shuffler: settle, pairing, mode shuffles,
// overflow accounting, q drop recovery, saturation and asynchronous reset.
module tb_adc_sample_shuffler;

  localparam logic [63:0]  PAT_LO     = 64'h0706050403020100;
  localparam logic [63:0]  PAT_HI     = 64'h0F0E0D0C0B0A0908;
  localparam logic [127:0] EXP_1CH_B0 = 128'h8F8E8D8C8B8A89888786858483828180;
  localparam logic [127:0] EXP_2CH    = 128'h0F0D0B09070503010E0C0A0806040200;
  localparam logic [127:0] EXP_4CH    = 128'h0F0B07030E0A06020D0905010C080400;
  localparam logic [63:0]  DUMMY      = 64'hA5A5_5A5A_C3C3_3C3C;

  logic         adc_divclk = 1'b0;
  logic         rst = 1'b1;
  logic [63:0]  adc_data = '0;
  logic         serdes_ready = 1'b0;
  logic         ddr_ready = 1'b1;
  logic [1:0]   ch_mode = 2'b00;
  logic         fifo_full = 1'b0;
  logic [127:0] out_data;
  logic         out_valid;
  logic [1:0]   mode_active;
  logic [2:0]   overflow_count;
  logic         drop_sticky;

  int checks = 0;
  int errors = 0;
  int nfed = 0;

  adc_sample_shuffler #(
    .SETTLE_WORDS (16),
    .CNT_W        (3)
  ) dut (
    .adc_divclk     (adc_divclk),
    .rst            (rst),
    .adc_data       (adc_data),
    .serdes_ready   (serdes_ready),
    .ddr_ready      (ddr_ready),
    .ch_mode        (ch_mode),
    .fifo_full      (fifo_full),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .mode_active    (mode_active),
    .overflow_count (overflow_count),
    .drop_sticky    (drop_sticky)
  );

  always #5 adc_divclk = ~adc_divclk;

  function automatic logic [63:0] inc_word(input int n);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'((8*n + k) & 255);
    return w;
  endfunction

  task automatic tick();
    @(posedge adc_divclk);
    #1;
  endtask

  task automatic feed(input logic [63:0] w);
    adc_data = w;
    tick();
    nfed++;
  endtask

  task automatic start_run();
    int vcount;
    vcount = 0;
    serdes_ready = 1'b1;
    adc_data = DUMMY;
    tick();
    for (int n = 0; n < 16; n++) begin
      adc_data = inc_word(n);
      tick();
      if (out_valid === 1'b1) vcount++;
    end
    checks++;
    if (vcount !== 0) begin
      errors++;
      $display("FAIL settle_discard: out_valid pulses %0d, required 0", vcount);
    end
    nfed = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++;
    if (out_data !== 128'd0) begin errors++; $display("FAIL reset_out_data: got %h required 0", out_data); end
    checks++;
    if (mode_active !== 2'b00) begin errors++; $display("FAIL reset_mode_active: got %b required 00", mode_active); end
    checks++;
    if (overflow_count !== 3'd0) begin errors++; $display("FAIL reset_overflow_count: got %0d required 0", overflow_count); end
    checks++;
    if (drop_sticky !== 1'b0) begin errors++; $display("FAIL reset_drop_sticky: got %b required 0", drop_sticky); end
  endtask

  task automatic test_settle_1ch();
    logic exp_v;
    logic [127:0] exp_d;
    start_run();
    for (int n = 16; n < 26; n++) begin
      feed(inc_word(n));
      exp_v = (n % 2 == 0) && (n >= 18);
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL run_1ch_valid word %0d: got %b required %b", n, out_valid, exp_v);
      end
      if (exp_v) begin
        exp_d = (n == 18) ? EXP_1CH_B0 : {inc_word(n-1), inc_word(n-2)};
        checks++;
        if (out_data !== exp_d) begin
          errors++;
          $display("FAIL run_1ch_data word %0d: got %h required %h", n, out_data, exp_d);
        end
      end
    end
  endtask

  task automatic test_mode_2ch();
    ch_mode = 2'b01;
    for (int i = 0; i < 4; i++) feed(inc_word(100 + i));
    checks++;
    if (mode_active !== 2'b01) begin errors++; $display("FAIL mode_2ch_active: got %b required 01", mode_active); end
    feed(PAT_LO);
    feed(PAT_HI);
    feed(DUMMY);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mode_2ch_valid: got %b required 1", out_valid); end
    checks++;
    if (out_data !== EXP_2CH) begin errors++; $display("FAIL mode_2ch_data: got %h required %h", out_data, EXP_2CH); end
    feed(DUMMY);
  endtask

  task automatic test_mode_4ch_toggle();
    feed(DUMMY);
    ch_mode = 2'b10;
    feed(DUMMY);
    checks++;
    if (mode_active !== 2'b01) begin errors++; $display("FAIL mode_toggle_a: got %b required 01", mode_active); end
    feed(DUMMY);
    checks++;
    if (mode_active !== 2'b01) begin errors++; $display("FAIL mode_toggle_b: got %b required 01", mode_active); end
    feed(DUMMY);
    checks++;
    if (mode_active !== 2'b01) begin errors++; $display("FAIL mode_hold_phase1: got %b required 01", mode_active); end
    feed(PAT_LO);
    checks++;
    if (mode_active !== 2'b10) begin errors++; $display("FAIL mode_load_phase0: got %b required 10", mode_active); end
    feed(PAT_HI);
    feed(DUMMY);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mode_4ch_valid: got %b required 1", out_valid); end
    checks++;
    if (out_data !== EXP_4CH) begin errors++; $display("FAIL mode_4ch_data: got %h required %h", out_data, EXP_4CH); end
    feed(DUMMY);
  endtask

  task automatic test_overflow();
    int vcount;
    vcount = 0;
    fifo_full = 1'b1;
    for (int i = 0; i < 6; i++) begin
      feed(DUMMY);
      if (i > 0 && out_valid === 1'b1) vcount++;
    end
    fifo_full = 1'b0;
    feed(PAT_LO);
    if (out_valid === 1'b1) vcount++;
    checks++;
    if (vcount !== 0) begin errors++; $display("FAIL overflow_no_strobe: pulses %0d required 0", vcount); end
    checks++;
    if (overflow_count !== 3'd3) begin errors++; $display("FAIL overflow_count: got %0d required 3", overflow_count); end
    checks++;
    if (drop_sticky !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %b required 1", drop_sticky); end
    feed(PAT_HI);
    feed(DUMMY);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL overflow_realign_valid: got %b required 1", out_valid); end
    checks++;
    if (out_data !== EXP_4CH) begin errors++; $display("FAIL overflow_realign_data: got %h required %h", out_data, EXP_4CH); end
    feed(DUMMY);
  endtask

  task automatic test_serdes_drop();
    int vcount;
    vcount = 0;
    feed(PAT_LO);
    serdes_ready = 1'b0;
    fifo_full = 1'b1;
    feed(PAT_HI);
    if (out_valid === 1'b1) vcount++;
    fifo_full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      feed(DUMMY);
      if (out_valid === 1'b1) vcount++;
    end
    checks++;
    if (vcount !== 0) begin errors++; $display("FAIL half_pair_discarded: pulses %0d required 0", vcount); end
    checks++;
    if (overflow_count !== 3'd3) begin errors++; $display("FAIL drop_no_count: got %0d required 3", overflow_count); end
    start_run();
    feed(PAT_LO);
    feed(PAT_HI);
    feed(DUMMY);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL fresh_low_valid: got %b required 1", out_valid); end
    checks++;
    if (out_data !== EXP_4CH) begin errors++; $display("FAIL fresh_low_data: got %h required %h", out_data, EXP_4CH); end
    feed(DUMMY);
  endtask

  task automatic test_saturation();
    fifo_full = 1'b1;
    for (int i = 0; i < 6; i++) feed(DUMMY);
    checks++;
    if (overflow_count !== 3'd6) begin errors++; $display("FAIL sat_near_full: got %0d required 6", overflow_count); end
    for (int i = 0; i < 4; i++) feed(DUMMY);
    checks++;
    if (overflow_count !== 3'd7) begin errors++; $display("FAIL sat_hold: got %0d required 7", overflow_count); end
    fifo_full = 1'b0;
  endtask

  task automatic test_async_reset();
    feed(PAT_LO);
    feed(PAT_HI);
    feed(DUMMY);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL prereset_valid: got %b required 1", out_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid: got %b required 0", out_valid); end
    checks++;
    if (out_data !== 128'd0) begin errors++; $display("FAIL async_out_data: got %h required 0", out_data); end
    checks++;
    if (mode_active !== 2'b00) begin errors++; $display("FAIL async_mode_active: got %b required 00", mode_active); end
    checks++;
    if (overflow_count !== 3'd0) begin errors++; $display("FAIL async_overflow_count: got %0d required 0", overflow_count); end
    checks++;
    if (drop_sticky !== 1'b0) begin errors++; $display("FAIL async_drop_sticky: got %b required 0", drop_sticky); end
    tick();
    rst = 1'b0;
    serdes_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_settle_1ch();
    test_mode_2ch();
    test_mode_4ch_toggle();
    test_overflow();
    test_serdes_drop();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
